// File: rtl/montgomery_exp_if.sv
// montgomery_exp_if: request/result and multiplier-side signals of the Montgomery exponentiator.
interface montgomery_exp_if #(
  parameter int WIDTH  = 1024,
  parameter int ELEN_W = 11
);
  logic              start;
  logic [WIDTH-1:0]  in_x;
  logic [WIDTH-1:0]  in_e;
  logic [ELEN_W-1:0] in_e_len;
  logic [WIDTH-1:0]  in_m;
  logic [WIDTH-1:0]  in_r;
  logic [WIDTH-1:0]  in_r2;
  logic              mult_start;
  logic [WIDTH-1:0]  mult_a;
  logic [WIDTH-1:0]  mult_b;
  logic [WIDTH-1:0]  mult_m;
  logic [WIDTH-1:0]  mult_result;
  logic              mult_done;
  logic [WIDTH-1:0]  result;
  logic              busy;
  logic              done;
  modport master (
    output start, in_x, in_e, in_e_len, in_m, in_r, in_r2, mult_result, mult_done,
    input  mult_start, mult_a, mult_b, mult_m, result, busy, done
  );
  modport slave (
    input  start, in_x, in_e, in_e_len, in_m, in_r, in_r2, mult_result, mult_done,
    output mult_start, mult_a, mult_b, mult_m, result, busy, done
  );
endinterface

// File: rtl/montgomery_exp.sv
// montgomery_exp: left-to-right square-and-multiply X^E mod M driving an external Montgomery multiplier.
module montgomery_exp #(
  parameter int WIDTH  = 1024,
  parameter int ELEN_W = 11
) (
  input logic             clk,
  input logic             reset,
  montgomery_exp_if.slave bus
);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  typedef enum logic [2:0] {IDLE, TOMONT, SQUARE, MULT, FROMMONT, FINISH} state_t;
  state_t            r_state;
  logic              r_wait;
  logic [WIDTH-1:0]  r_x, r_e, r_m, r_r, r_r2, r_xm, r_acc;
  logic [IW-1:0]     r_i;
  logic              r_tz;
  logic              r_busy, r_done, r_ms;
  logic [WIDTH-1:0]  r_a, r_b, r_mm, r_res;
  logic [ELEN_W-1:0] w_t;
  logic [IW-1:0]     w_i0;
  logic              w_step, w_last;
  assign w_t    = (bus.in_e_len > ELEN_W'(WIDTH)) ? ELEN_W'(WIDTH) : bus.in_e_len;
  assign w_i0   = IW'(w_t - 1'b1);
  assign w_last = (r_i == '0);
  // An index step follows every MULT, and every SQUARE whose exponent bit is clear.
  assign w_step = (r_state == MULT) || (r_state == SQUARE && !r_e[r_i]);
  assign bus.mult_start = r_ms;
  assign bus.mult_a     = r_a;
  assign bus.mult_b     = r_b;
  assign bus.mult_m     = r_mm;
  assign bus.result     = r_res;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_wait  <= 1'b0;
      r_x     <= '0;
      r_e     <= '0;
      r_m     <= '0;
      r_r     <= '0;
      r_r2    <= '0;
      r_xm    <= '0;
      r_acc   <= '0;
      r_i     <= '0;
      r_tz    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ms    <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_mm    <= '0;
      r_res   <= '0;
    end else begin
      r_ms   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (bus.start) begin
          r_x     <= bus.in_x;
          r_e     <= bus.in_e;
          r_m     <= bus.in_m;
          r_r     <= bus.in_r;
          r_r2    <= bus.in_r2;
          r_i     <= w_i0;
          r_tz    <= (w_t == '0);
          r_busy  <= 1'b1;
          r_wait  <= 1'b0;
          r_state <= TOMONT;
        end
        FINISH: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: if (!r_wait) begin
          r_ms   <= 1'b1;
          r_wait <= 1'b1;
          r_a    <= (r_state == TOMONT) ? r_x : r_acc;
          r_b    <= (r_state == TOMONT) ? r_r2 : (r_state == SQUARE) ? r_acc :
                    (r_state == MULT) ? r_xm : WIDTH'(1);
          r_mm   <= r_m;
        end else if (bus.mult_done) begin
          r_wait  <= 1'b0;
          r_acc   <= (r_state == TOMONT) ? r_r : bus.mult_result;
          if (r_state == TOMONT) r_xm <= bus.mult_result;
          if (w_step && !w_last) r_i <= r_i - 1'b1;
          if (r_state == FROMMONT) begin
            r_res  <= bus.mult_result;
            r_done <= 1'b1;
          end
          r_state <= (r_state == TOMONT) ? (r_tz ? FROMMONT : SQUARE) :
                     (r_state == FROMMONT) ? FINISH :
                     !w_step ? MULT : w_last ? FROMMONT : SQUARE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_montgomery_exp.sv
// tb_montgomery_exp: directed and random modexp runs against a variable-latency Montgomery multiplier model.
module tb_montgomery_exp;
  localparam int W  = 8;
  localparam int M  = 197;
  localparam int R  = 59;
  localparam int R2 = 132;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  montgomery_exp_if #(.WIDTH(W), .ELEN_W(11)) bus ();
  montgomery_exp #(.WIDTH(W), .ELEN_W(11)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  int n_chk = 0;
  int n_pass = 0;
  int ns = 0, nd = 0, stab_err = 0;
  logic md_model = 1'b0, md_inj = 1'b0, pend = 1'b0;
  int cnt = 0;
  logic [W-1:0] pa = '0, pb = '0, pm = '0, mres = '0;
  assign bus.mult_done   = md_model | md_inj;
  assign bus.mult_result = mres;
  function automatic int mont(input int a, input int b, input int m);
    if (m == 0) return 0;
    for (int r = 0; r < m; r++)
      if ((r * 256) % m == (a * b) % m) return r;
    return 0;
  endfunction
  function automatic int modexp(input int x, input int e, input int t, input int m);
    int r = 1;
    for (int i = t - 1; i >= 0; i--) begin
      r = (r * r) % m;
      if ((e >> i) & 1) r = (r * x) % m;
    end
    return r % m;
  endfunction
  function automatic int popc(input int e, input int t);
    int c = 0;
    for (int i = 0; i < t; i++) c += (e >> i) & 1;
    return c;
  endfunction
  // Multiplier model: captures operands on mult_start, answers 3..20 cycles later.
  always @(posedge clk) begin
    md_model <= 1'b0;
    if (bus.mult_start) begin
      pa <= bus.mult_a; pb <= bus.mult_b; pm <= bus.mult_m;
      cnt <= $urandom_range(20, 3);
      pend <= 1'b1;
    end else if (pend) begin
      if (cnt <= 1) begin
        md_model <= 1'b1;
        mres <= W'(mont(int'(pa), int'(pb), int'(pm)));
        pend <= 1'b0;
      end else cnt <= cnt - 1;
    end
  end
  always @(negedge clk) begin
    if (bus.mult_start) ns++;
    if (bus.done) nd++;
    if (pend && (bus.mult_a != pa || bus.mult_b != pb || bus.mult_m != pm)) stab_err++;
  end
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic launch(input int x, input int e, input int t);
    bus.start = 1'b1;
    bus.in_x = W'(x); bus.in_e = W'(e); bus.in_e_len = 11'(t);
    bus.in_m = W'(M); bus.in_r = W'(R); bus.in_r2 = W'(R2);
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  task automatic wait_done(output int res, output bit busy_bad);
    int k = 0;
    busy_bad = 1'b0;
    while (!bus.done && k < 5000) begin
      if (!bus.busy) busy_bad = 1'b1;
      @(negedge clk);
      k++;
    end
    chk("done_seen", int'(bus.done), 1);
    res = int'(bus.result);
    @(negedge clk);
  endtask
  task automatic run(input string tag, input int x, input int e, input int t, input int tc);
    int ns0, nd0, st0, res;
    bit bb;
    ns0 = ns; nd0 = nd; st0 = stab_err;
    launch(x, e, t);
    wait_done(res, bb);
    chk({tag, "_result"}, res, modexp(x, e, tc, M));
    chk({tag, "_pulses"}, ns - ns0, 2 + tc + popc(e, tc));
    chk({tag, "_dones"}, nd - nd0, 1);
    chk({tag, "_stable"}, stab_err - st0, 0);
    chk({tag, "_busy"}, int'(bb), 0);
  endtask
  initial begin
    int res, ns0, nd0, k;
    bit bb;
    bus.start = 1'b0; bus.in_x = '0; bus.in_e = '0; bus.in_e_len = '0;
    bus.in_m = '0; bus.in_r = '0; bus.in_r2 = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_mstart", int'(bus.mult_start), 0);
    chk("rst_result", int'(bus.result), 0);
    chk("rst_ops", int'({bus.mult_a, bus.mult_b, bus.mult_m}), 0);
    reset = 1'b0;
    chk("x5e3_ref", modexp(5, 3, 2, M), 125);
    run("x5e3", 5, 3, 2, 2);
    chk("x5e3_value", int'(bus.result), 125);
    run("x2e10", 2, 10, 4, 4);
    chk("x2e10_value", int'(bus.result), 39);
    run("x7e0", 7, 0, 0, 0);
    chk("x7e0_value", int'(bus.result), 1);
    run("clamp", 3, 255, 12, 8);
    // Restart while busy must be ignored, as must a stray mult_done in IDLE.
    ns0 = ns; nd0 = nd;
    launch(5, 3, 2);
    repeat (4) @(negedge clk);
    launch(9, 7, 3);
    repeat (6) @(negedge clk);
    launch(11, 1, 1);
    wait_done(res, bb);
    chk("restart_result", res, 125);
    chk("restart_pulses", ns - ns0, 6);
    repeat (3) @(negedge clk);
    md_inj = 1'b1;
    @(negedge clk);
    md_inj = 1'b0;
    repeat (10) @(negedge clk);
    chk("spur_pulses", ns - ns0, 6);
    chk("spur_dones", nd - nd0, 1);
    chk("spur_result", int'(bus.result), 125);
    chk("spur_busy", int'(bus.busy), 0);
    // Abort during the third multiply, then let its late mult_done arrive.
    ns0 = ns; nd0 = nd;
    launch(5, 3, 2);
    k = 0;
    while (ns - ns0 < 3 && k < 2000) begin @(negedge clk); k++; end
    chk("abort_reach3", ns - ns0, 3);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_result", int'(bus.result), 0);
    k = 0;
    while (pend && k < 100) begin @(negedge clk); k++; end
    repeat (3) @(negedge clk);
    chk("abort_dones", nd - nd0, 0);
    chk("abort_pulses", ns - ns0, 3);
    run("after_abort", 5, 3, 2, 2);
    chk("after_abort_value", int'(bus.result), 125);
    for (int r = 0; r < 200; r++) begin
      int x, e;
      x = $urandom_range(196, 0);
      e = $urandom_range(255, 0);
      ns0 = ns;
      launch(x, e, 8);
      wait_done(res, bb);
      chk($sformatf("rand%0d_x%0d_e%0d", r, x, e), res, modexp(x, e, 8, M));
      chk($sformatf("rand%0d_busy", r), int'(bb), 0);
      chk($sformatf("rand%0d_pulses", r), ns - ns0, 10 + popc(e, 8));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
